// File: rtl/upfpga_errmon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : upfpga_errmon
// Purpose  : Error monitor and CPU bus fabric for a partitioned FPGA.
//            Routes external CPU bus accesses either to one of NPART
//            partitions or to a local register bank. The local bank counts
//            rising edges on NERR error inputs, keeps per-channel stickies,
//            drives error-injection outputs and flags bus timeouts.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock (single domain)
//   rst_         in   asynchronous active-low reset
//   eupa[23:0]   in   CPU address; [23:12] selects partition / local page
//   eupce_       in   CPU chip enable, active low (asynchronous to clk)
//   euprnw       in   1 = read, 0 = write
//   eupdi[31:0]  in   CPU write data
//   eupdo[31:0]  out  CPU read data
//   eupack       out  access acknowledge
//   eupint       out  interrupt (registered)
//   upce_part_   out  per-partition chip enable, active low, combinational
//   updo_part    in   partition read data, part i at [32i+31:32i]
//   upack_part   in   partition acknowledges
//   upint_part   in   partition interrupts
//   error        in   error channels
//   testmode     out  mode register
//   inserr       out  error injection (level OR one-shot pulse)
// ============================================================================
module upfpga_errmon #(
    parameter int          NPART = 3,
    parameter int          NERR  = 16,
    parameter int          CNTW  = 16,
    parameter int          TOUT  = 255,
    parameter logic [11:0] RBASE = 12'hf00
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [23:0]          eupa,
    input  logic                 eupce_,
    input  logic                 euprnw,
    input  logic [31:0]          eupdi,
    output logic [31:0]          eupdo,
    output logic                 eupack,
    output logic                 eupint,
    output logic [NPART-1:0]     upce_part_,
    input  logic [32*NPART-1:0]  updo_part,
    input  logic [NPART-1:0]     upack_part,
    input  logic [NPART-1:0]     upint_part,
    input  logic [NERR-1:0]      error,
    output logic [7:0]           testmode,
    output logic [NERR-1:0]      inserr
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int              c_tw       = $clog2(TOUT + 1);
    localparam logic [c_tw-1:0] c_tout     = c_tw'(TOUT);
    localparam logic [c_tw-1:0] c_tone     = c_tw'(1);
    localparam logic [CNTW-1:0] c_cnt_max  = '1;
    localparam logic [CNTW-1:0] c_cnt_one  = CNTW'(1);
    localparam logic [31:0]     c_tout_dat = 32'hDEAD_BEEF;

    localparam logic [7:0] c_off_mode   = 8'h00;
    localparam logic [7:0] c_off_level  = 8'h01;
    localparam logic [7:0] c_off_oneshot = 8'h02;
    localparam logic [7:0] c_off_sticky = 8'h03;
    localparam logic [7:0] c_off_mask   = 8'h04;
    localparam logic [7:0] c_off_status = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LSTB  = 3'd1,
        S_LACK  = 3'd2,
        S_PWAIT = 3'd3,
        S_TOUT  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_tw-1:0]   r_timer;
    logic [c_tw-1:0]   w_timer_nxt;

    logic              r_ce_m;
    logic              r_ce_s;
    logic              r_ce_q;
    logic              w_ce_fall;

    logic [11:0]       w_page;
    logic [7:0]        w_off;
    logic              w_local_page;
    logic [4:0]        w_cidx;
    logic              w_cnt_sel;

    logic [31:0]       w_part_do;
    logic              w_part_ack;

    logic              w_lstb;
    logic              w_wr;
    logic              w_rd;
    logic              w_wr_mode;
    logic              w_wr_level;
    logic              w_wr_oneshot;
    logic              w_wr_sticky;
    logic              w_wr_mask;
    logic              w_wr_status;

    logic [7:0]        r_mode;
    logic [NERR-1:0]   r_level;
    logic [NERR-1:0]   r_pulse;
    logic [NERR-1:0]   r_sticky;
    logic [NERR-1:0]   r_mask;
    logic              r_status;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rdata;
    logic              r_int;

    logic              r_armed;
    logic [NERR-1:0]   r_err_q;
    logic [NERR-1:0]   w_edge;
    logic [NERR-1:0]   w_cnt_clr;
    logic [CNTW-1:0]   r_cnt [NERR];

    // Address bits that take no part in decoding; folded here so they are
    // visibly accounted for.
    logic              w_unused;
    assign w_unused = ^{eupa[11:8], eupdi};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_page       = eupa[23:12];
    assign w_off        = eupa[7:0];
    assign w_local_page = (w_page == RBASE);
    // Counters live at offsets 0x40..0x5F.
    assign w_cnt_sel    = (w_off[7:5] == 3'b010);
    assign w_cidx       = w_off[4:0];

    generate
        for (genvar i = 0; i < NPART; i++) begin : g_part
            assign upce_part_[i] = ~(~eupce_ & (w_page == 12'(i)));
        end
    endgenerate

    always_comb begin
        w_part_do = '0;
        for (int i = 0; i < NPART; i++) begin
            w_part_do = w_part_do | updo_part[32*i +: 32];
        end
    end
    assign w_part_ack = |upack_part;

    // ------------------------------------------------------------------
    // Chip-enable synchronizer; idles high so reset never looks like a
    // falling edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ce_m <= 1'b1;
            r_ce_s <= 1'b1;
            r_ce_q <= 1'b1;
        end else begin
            r_ce_m <= eupce_;
            r_ce_s <= r_ce_m;
            r_ce_q <= r_ce_s;
        end
    end
    assign w_ce_fall = r_ce_q & ~r_ce_s;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        eupack      = 1'b0;
        eupdo       = '0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (w_ce_fall) begin
                    // Anything that is not the local page (partition or
                    // unmapped) waits for a partition ack or the timeout.
                    w_state_nxt = w_local_page ? S_LSTB : S_PWAIT;
                end
            end
            S_LSTB: begin
                w_state_nxt = S_LACK;
            end
            S_LACK: begin
                eupack = 1'b1;
                eupdo  = r_rdata;
                if (r_ce_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PWAIT: begin
                eupack = w_part_ack;
                eupdo  = w_part_do;
                if (r_ce_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_timer == c_tout) begin
                    w_state_nxt = S_TOUT;
                end else if (!w_part_ack) begin
                    w_timer_nxt = r_timer + c_tone;
                end
            end
            S_TOUT: begin
                eupack = 1'b1;
                eupdo  = c_tout_dat;
                if (r_ce_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Local register strobes (active during the single LSTB cycle)
    // ------------------------------------------------------------------
    assign w_lstb       = (r_state == S_LSTB);
    assign w_wr         = w_lstb & ~euprnw;
    assign w_rd         = w_lstb &  euprnw;
    assign w_wr_mode    = w_wr & (w_off == c_off_mode);
    assign w_wr_level   = w_wr & (w_off == c_off_level);
    assign w_wr_oneshot = w_wr & (w_off == c_off_oneshot);
    assign w_wr_sticky  = w_wr & (w_off == c_off_sticky);
    assign w_wr_mask    = w_wr & (w_off == c_off_mask);
    assign w_wr_status  = w_wr & (w_off == c_off_status);

    always_comb begin
        w_cnt_clr = '0;
        for (int i = 0; i < NERR; i++) begin
            w_cnt_clr[i] = w_rd & w_cnt_sel & (w_cidx == 5'(i));
        end
    end

    // Read mux; unmapped offsets and counters beyond NERR return zero.
    always_comb begin
        w_rdata = '0;
        if (w_cnt_sel) begin
            for (int i = 0; i < NERR; i++) begin
                if (w_cidx == 5'(i)) begin
                    w_rdata[CNTW-1:0] = r_cnt[i];
                end
            end
        end else begin
            case (w_off)
                c_off_mode:   w_rdata[7:0]      = r_mode;
                c_off_level:  w_rdata[NERR-1:0] = r_level;
                c_off_sticky: w_rdata[NERR-1:0] = r_sticky;
                c_off_mask:   w_rdata[NERR-1:0] = r_mask;
                c_off_status: w_rdata[0]        = r_status;
                default:      w_rdata           = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error edge detection. r_armed holds off the first cycle after reset
    // so an input already high at release is not counted.
    // ------------------------------------------------------------------
    assign w_edge = error & ~r_err_q & {NERR{r_armed}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_mode   <= '0;
            r_level  <= '0;
            r_pulse  <= '0;
            r_sticky <= '0;
            r_mask   <= '0;
            r_status <= 1'b0;
            r_rdata  <= '0;
            r_int    <= 1'b0;
            r_armed  <= 1'b0;
            r_err_q  <= '0;
        end else begin
            r_armed <= 1'b1;
            r_err_q <= error;

            if (w_wr_mode) begin
                r_mode <= eupdi[7:0];
            end
            if (w_wr_level) begin
                r_level <= eupdi[NERR-1:0];
            end
            if (w_wr_mask) begin
                r_mask <= eupdi[NERR-1:0];
            end
            // One-shot injection lasts exactly the cycle after the write.
            r_pulse <= w_wr_oneshot ? eupdi[NERR-1:0] : '0;

            // A new edge wins over a simultaneous write-one-to-clear.
            r_sticky <= (r_sticky & ~(w_wr_sticky ? eupdi[NERR-1:0] : '0))
                        | w_edge;
            r_status <= (r_status & ~(w_wr_status & eupdi[0]))
                        | (r_state == S_TOUT);

            if (w_lstb) begin
                r_rdata <= w_rd ? w_rdata : '0;
            end

            r_int <= (|upint_part) | (|(r_sticky & r_mask))
                     | (r_status & r_mode[7]);
        end
    end

    // Saturating counters; a read-clear that coincides with an edge leaves
    // the counter at one (the read itself returns the old value).
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < NERR; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NERR; i++) begin
                if (w_cnt_clr[i]) begin
                    r_cnt[i] <= w_edge[i] ? c_cnt_one : '0;
                end else if (w_edge[i] && (r_cnt[i] != c_cnt_max)) begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign eupint   = r_int;
    assign testmode = r_mode;
    assign inserr   = r_level | r_pulse;

endmodule

`default_nettype wire
